// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencing controller between the EXE stage and the iterative
// divider core. It launches the core with latched operands, stalls the pipeline
// until a result is captured, short-circuits divide-by-zero, aborts on flush and
// bounds core latency with a watchdog.
module div_seq_ctrl #(
    parameter int DATA_W   = 32,
    parameter int MAX_BUSY = 40,
    parameter int CNT_W    = 6
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst_n,
    input  logic                  flush_i,
    input  logic                  stall_later_i,
    input  logic                  req_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     op1_i,
    input  logic [DATA_W-1:0]     op2_i,
    output logic                  core_start_o,
    output logic                  core_cancel_o,
    output logic                  core_signed_o,
    output logic [DATA_W-1:0]     core_op1_o,
    output logic [DATA_W-1:0]     core_op2_o,
    input  logic                  core_ready_i,
    input  logic [2*DATA_W-1:0]   core_res_i,
    output logic                  stallreq_o,
    output logic                  res_valid_o,
    output logic [2*DATA_W-1:0]   res_o,
    output logic                  dz_o,
    output logic                  tmo_o,
    output logic [CNT_W-1:0]      busy_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BUSY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BUSY - 1);

    state_t               state_q;
    state_t               state_d;
    logic                 start_d;
    logic                 cancel_d;
    logic                 signed_d;
    logic [DATA_W-1:0]    op1_d;
    logic [DATA_W-1:0]    op2_d;
    logic [2*DATA_W-1:0]  res_d;
    logic                 dz_d;
    logic                 tmo_d;
    logic [CNT_W-1:0]     cnt_d;

    // State register and all registered outputs; everything clears on reset.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q       <= S_IDLE;
            core_start_o  <= 1'b0;
            core_cancel_o <= 1'b0;
            core_signed_o <= 1'b0;
            core_op1_o    <= '0;
            core_op2_o    <= '0;
            res_o         <= '0;
            dz_o          <= 1'b0;
            tmo_o         <= 1'b0;
            busy_cnt_o    <= '0;
        end else begin
            state_q       <= state_d;
            core_start_o  <= start_d;
            core_cancel_o <= cancel_d;
            core_signed_o <= signed_d;
            core_op1_o    <= op1_d;
            core_op2_o    <= op2_d;
            res_o         <= res_d;
            dz_o          <= dz_d;
            tmo_o         <= tmo_d;
            busy_cnt_o    <= cnt_d;
        end
    end

    // Next-state, next-register values and the combinational stall request.
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        cancel_d   = 1'b0;
        signed_d   = core_signed_o;
        op1_d      = core_op1_o;
        op2_d      = core_op2_o;
        res_d      = res_o;
        dz_d       = dz_o;
        tmo_d      = tmo_o;
        cnt_d      = busy_cnt_o;
        stallreq_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_i && !flush_i) begin
                    stallreq_o = 1'b1;
                    if (op2_i != '0) begin
                        signed_d = signed_i;
                        op1_d    = op1_i;
                        op2_d    = op2_i;
                        cnt_d    = '0;
                        start_d  = 1'b1;
                        state_d  = S_BUSY;
                    end else begin
                        // Zero divisor: answer directly, core stays idle.
                        res_d   = {op1_i, {DATA_W{1'b1}}};
                        dz_d    = 1'b1;
                        tmo_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end

            S_BUSY: begin
                stallreq_o = !flush_i;
                cnt_d      = (busy_cnt_o == CNT_SAT) ? busy_cnt_o : busy_cnt_o + 1'b1;
                if (flush_i || !req_i) begin
                    // Abort wins over a same-cycle ready; result is dropped.
                    cancel_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (core_ready_i) begin
                    res_d   = core_res_i;
                    state_d = S_DONE;
                end else if (busy_cnt_o == CNT_LAST) begin
                    cancel_d = 1'b1;
                    res_d    = '0;
                    tmo_d    = 1'b1;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                if (flush_i || !stall_later_i) begin
                    dz_d    = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The result is presented for exactly the cycles spent in DONE.
    assign res_valid_o = (state_q == S_DONE);

endmodule
